// File: rtl/reg_bank_bus_ctrl_if.sv
// Request/response handshake and register-cell strobe bundle for reg_bank_bus_ctrl.
// The slave modport is the controller; the master modport is the requester and cell-bank side.
interface reg_bank_bus_ctrl_if #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2
);
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_op;
    logic [AddrBits-1:0] req_addr;
    logic [NrOfBits-1:0] req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [NrOfBits-1:0] rsp_rdata;
    logic                rsp_err;
    logic [NrOfRegs-1:0] reg_ce;
    logic [NrOfRegs-1:0] reg_cs;
    logic [NrOfRegs-1:0] reg_pre;
    logic [NrOfBits-1:0] reg_d;
    logic [NrOfBits-1:0] bus_q;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, reg_ce, reg_cs, reg_pre, reg_d
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, bus_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, reg_ce, reg_cs, reg_pre, reg_d
    );
endinterface

// File: rtl/reg_bank_bus_ctrl.sv
// Sequencer turning single read/write/preset requests into strobes for a bank of
// tri-state register cells, and sampling the shared Q bus for reads.
module reg_bank_bus_ctrl #(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 4,
    parameter int AddrBits = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    reg_bank_bus_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, WR, PRE, RD_DRV, RD_CAP, RESP} state_t;

    state_t              state_reg, state_next;
    logic                req_ready_reg, req_ready_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [NrOfBits-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic                rsp_err_reg, rsp_err_next;
    logic [NrOfRegs-1:0] reg_ce_reg, reg_ce_next;
    logic [NrOfRegs-1:0] reg_cs_reg, reg_cs_next;
    logic [NrOfRegs-1:0] reg_pre_reg, reg_pre_next;
    logic [NrOfBits-1:0] reg_d_reg, reg_d_next;

    logic [NrOfRegs-1:0] req_sel;
    logic                req_bad;

    generate
        for (genvar gi = 0; gi < NrOfRegs; gi++) begin : g_sel
            assign req_sel[gi] = (bus.req_addr == AddrBits'(gi));
        end
    endgenerate

    assign req_bad = (32'(bus.req_addr) >= NrOfRegs) || (bus.req_op == 2'b11);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            reg_ce_reg    <= '0;
            reg_cs_reg    <= '1;
            reg_pre_reg   <= '0;
            reg_d_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            reg_ce_reg    <= reg_ce_next;
            reg_cs_reg    <= reg_cs_next;
            reg_pre_reg   <= reg_pre_next;
            reg_d_reg     <= reg_d_next;
        end
    end

    // The one-hot strobes themselves hold the latched address for the whole operation.
    always_comb begin
        state_next     = state_reg;
        req_ready_next = req_ready_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        reg_ce_next    = reg_ce_reg;
        reg_cs_next    = reg_cs_reg;
        reg_pre_next   = reg_pre_reg;
        reg_d_next     = reg_d_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid && req_ready_reg) begin
                    req_ready_next = 1'b0;
                    if (req_bad) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = '0;
                    end else if (bus.req_op == 2'b00) begin
                        state_next  = RD_DRV;
                        reg_cs_next = ~req_sel;
                    end else if (bus.req_op == 2'b01) begin
                        state_next  = WR;
                        reg_ce_next = req_sel;
                        reg_d_next  = bus.req_wdata;
                    end else begin
                        state_next   = PRE;
                        reg_pre_next = req_sel;
                    end
                end
            end
            WR: begin
                if (Tick) begin
                    state_next     = IDLE;
                    reg_ce_next    = '0;
                    req_ready_next = 1'b1;
                end
            end
            PRE: begin
                state_next     = IDLE;
                reg_pre_next   = '0;
                req_ready_next = 1'b1;
            end
            RD_DRV: begin
                state_next = RD_CAP;
            end
            RD_CAP: begin
                state_next     = RESP;
                rsp_rdata_next = bus.bus_q;
                rsp_err_next   = 1'b0;
                rsp_valid_next = 1'b1;
                reg_cs_next    = '1;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    rsp_err_next   = 1'b0;
                    req_ready_next = 1'b1;
                end
            end
            default: begin
                state_next     = IDLE;
                req_ready_next = 1'b1;
                reg_ce_next    = '0;
                reg_cs_next    = '1;
                reg_pre_next   = '0;
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.reg_ce    = reg_ce_reg;
    assign bus.reg_cs    = reg_cs_reg;
    assign bus.reg_pre   = reg_pre_reg;
    assign bus.reg_d     = reg_d_reg;
endmodule
